req_encoder8to3: RTL and testbench

REQ_ENCODER8TO3 -- requirements
Module: req_encoder8to3

---
 rtl/req_encoder8to3.sv | 87 ++++++++
 tb/tb_req_encoder8to3.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_encoder8to3.sv
// Request encoder: captures multi-hot requests into a pending set and presents
// one granted index at a time on a registered code/valid handshake.
module req_encoder8to3 #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       ready,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending,
  output logic       merged
);

  logic [2:0] code_q,    code_d;
  logic       valid_q,   valid_d;
  logic [7:0] pending_q, pending_d;
  logic       merged_q,  merged_d;

  logic [7:0] new_req;
  logic [7:0] cand;
  logic       slot_free;
  logic [2:0] grant_idx;
  logic [7:0] grant_oh;

  // Later loop iterations override earlier ones, so the scan direction sets priority.
  function automatic logic [2:0] pri(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (LOW_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    new_req   = en ? req : 8'h00;
    cand      = pending_q | new_req;
    slot_free = !valid_q || ready;
    grant_idx = pri(cand);
    grant_oh  = 8'h01 << grant_idx;

    code_d    = code_q;
    valid_d   = valid_q;
    pending_d = cand;
    merged_d  = |(new_req & pending_q);

    if (slot_free) begin
      if (|cand) begin
        code_d    = grant_idx;
        valid_d   = 1'b1;
        pending_d = cand & ~grant_oh;
      end else begin
        valid_d   = 1'b0;
        pending_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
      pending_q <= 8'h00;
      merged_q  <= 1'b0;
    end else begin
      code_q    <= code_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      merged_q  <= merged_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign merged  = merged_q;

endmodule

// File: tb/tb_req_encoder8to3.sv
// Bench for req_encoder8to3: lowest-first and highest-first instances share
// stimulus; a reference model feeds per-cycle expected state into queues.
module tb_req_encoder8to3;

  typedef struct packed {
    logic [2:0] code;
    logic       valid;
    logic [7:0] pend;
    logic       merged;
  } st_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       ready;
  logic [2:0] code_l, code_h;
  logic       valid_l, valid_h;
  logic [7:0] pending_l, pending_h;
  logic       merged_l, merged_h;

  int tests;
  int fails;

  st_t m_l, m_h;
  st_t q_l[$];
  st_t q_h[$];
  st_t got, exp_s;

  req_encoder8to3 #(.LOW_FIRST(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ready(ready),
    .code(code_l), .valid(valid_l), .pending(pending_l), .merged(merged_l)
  );

  req_encoder8to3 #(.LOW_FIRST(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ready(ready),
    .code(code_h), .valid(valid_h), .pending(pending_h), .merged(merged_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  function automatic st_t model(input st_t s, input logic e, input logic [7:0] r,
                                input logic rdy, input bit low);
    st_t        n;
    logic [7:0] nw;
    logic [7:0] cand;
    int         idx;
    n      = s;
    nw     = e ? r : 8'h00;
    cand   = s.pend | nw;
    n.merged = |(nw & s.pend);
    if (!s.valid || rdy) begin
      if (cand == 8'h00) begin
        n.valid = 1'b0;
        n.pend  = 8'h00;
      end else begin
        idx = -1;
        for (int i = 0; i < 8; i++) begin
          if (cand[i]) begin
            if (!low) idx = i;
            else if (idx < 0) idx = i;
          end
        end
        n.code  = idx[2:0];
        n.valid = 1'b1;
        n.pend  = cand;
        n.pend[idx] = 1'b0;
      end
    end else begin
      n.pend = cand;
    end
    return n;
  endfunction

  task automatic drive(input logic e, input logic [7:0] r, input logic rdy);
    en    = e;
    req   = r;
    ready = rdy;
    m_l = model(m_l, e, r, rdy, 1'b1);
    m_h = model(m_h, e, r, rdy, 1'b0);
    q_l.push_back(m_l);
    q_h.push_back(m_h);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req = 8'h00; ready = 1'b0;
    m_l = '0; m_h = '0;
    #12;
    tests++;
    if ({code_l, valid_l, pending_l, merged_l} !== 13'h0) begin
      fails++;
      $display("FAIL reset_lo: got %h required 0", {code_l, valid_l, pending_l, merged_l});
    end
    tests++;
    if ({code_h, valid_h, pending_h, merged_h} !== 13'h0) begin
      fails++;
      $display("FAIL reset_hi: got %h required 0", {code_h, valid_h, pending_h, merged_h});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    logic [2:0] el[4];
    logic [2:0] eh[4];
    logic       ev[4];
    el = '{3'd2, 3'd5, 3'd7, 3'd7};
    eh = '{3'd7, 3'd5, 3'd2, 3'd2};
    ev = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, (k == 0) ? 8'hA4 : 8'h00, 1'b1);
      got = {code_l, valid_l, pending_l, merged_l}; exp_s = q_l.pop_front();
      tests++;
      if (got !== exp_s) begin fails++; $display("FAIL prio_sb_lo step%0d: got %h required %h", k, got, exp_s); end
      got = {code_h, valid_h, pending_h, merged_h}; exp_s = q_h.pop_front();
      tests++;
      if (got !== exp_s) begin fails++; $display("FAIL prio_sb_hi step%0d: got %h required %h", k, got, exp_s); end
      tests++;
      if (valid_l !== ev[k] || (ev[k] && code_l !== el[k])) begin
        fails++; $display("FAIL prio_lo step%0d: code %0d valid %b required %0d/%b", k, code_l, valid_l, el[k], ev[k]);
      end
      tests++;
      if (valid_h !== ev[k] || (ev[k] && code_h !== eh[k])) begin
        fails++; $display("FAIL prio_hi step%0d: code %0d valid %b required %0d/%b", k, code_h, valid_h, eh[k], ev[k]);
      end
    end
    tests++;
    if (pending_l !== 8'h00 || pending_h !== 8'h00) begin
      fails++; $display("FAIL prio_drain: pending %h/%h required 00", pending_l, pending_h);
    end
  endtask

  task automatic test_merge();
    logic [7:0] rs[5];
    logic       ys[5];
    rs = '{8'h02, 8'h01, 8'h01, 8'h00, 8'h00};
    ys = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, rs[k], ys[k]);
      got = {code_l, valid_l, pending_l, merged_l}; exp_s = q_l.pop_front();
      tests++;
      if (got !== exp_s) begin fails++; $display("FAIL merge_sb_lo step%0d: got %h required %h", k, got, exp_s); end
      got = {code_h, valid_h, pending_h, merged_h}; exp_s = q_h.pop_front();
      tests++;
      if (got !== exp_s) begin fails++; $display("FAIL merge_sb_hi step%0d: got %h required %h", k, got, exp_s); end
      if (k == 2) begin
        tests++;
        if (merged_l !== 1'b1 || code_l !== 3'd1 || valid_l !== 1'b1 || pending_l !== 8'h01) begin
          fails++; $display("FAIL merge_pulse: merged %b code %0d pend %h required 1/1/01", merged_l, code_l, pending_l);
        end
      end
      if (k == 3) begin
        tests++;
        if (merged_l !== 1'b0 || code_l !== 3'd0 || valid_l !== 1'b1 || pending_l !== 8'h00) begin
          fails++; $display("FAIL merge_grant: merged %b code %0d valid %b pend %h required 0/0/1/00", merged_l, code_l, valid_l, pending_l);
        end
      end
      if (k == 4) begin
        tests++;
        if (valid_l !== 1'b0) begin fails++; $display("FAIL merge_nomore: valid %b required 0", valid_l); end
      end
    end
  endtask

  task automatic test_enable();
    logic [2:0] el[4];
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'hFF, 1'b1);
      got = {code_l, valid_l, pending_l, merged_l}; exp_s = q_l.pop_front();
      tests++;
      if (got !== exp_s || valid_l !== 1'b0 || pending_l !== 8'h00 || merged_l !== 1'b0) begin
        fails++; $display("FAIL en_block step%0d: got %h required %h", k, got, exp_s);
      end
      void'(q_h.pop_front());
    end
    el = '{3'd3, 3'd4, 3'd5, 3'd5};
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive(1'b1, 8'h38, 1'b0);
      else drive(1'b0, 8'hFF, 1'b1);
      got = {code_l, valid_l, pending_l, merged_l}; exp_s = q_l.pop_front();
      tests++;
      if (got !== exp_s) begin fails++; $display("FAIL en_drain_sb_lo step%0d: got %h required %h", k, got, exp_s); end
      got = {code_h, valid_h, pending_h, merged_h}; exp_s = q_h.pop_front();
      tests++;
      if (got !== exp_s) begin fails++; $display("FAIL en_drain_sb_hi step%0d: got %h required %h", k, got, exp_s); end
      tests++;
      if (valid_l !== (k < 3) || (k < 3 && code_l !== el[k])) begin
        fails++; $display("FAIL en_drain step%0d: code %0d valid %b required %0d", k, code_l, valid_l, el[k]);
      end
    end
  endtask

  task automatic test_regrant();
    for (int k = 0; k < 4; k++) begin
      if (k < 2) drive(1'b1, 8'h08, 1'b0);
      else drive(1'b0, 8'h00, 1'b1);
      got = {code_l, valid_l, pending_l, merged_l}; exp_s = q_l.pop_front();
      tests++;
      if (got !== exp_s) begin fails++; $display("FAIL regrant_sb_lo step%0d: got %h required %h", k, got, exp_s); end
      got = {code_h, valid_h, pending_h, merged_h}; exp_s = q_h.pop_front();
      tests++;
      if (got !== exp_s) begin fails++; $display("FAIL regrant_sb_hi step%0d: got %h required %h", k, got, exp_s); end
      if (k == 1) begin
        tests++;
        if (code_l !== 3'd3 || valid_l !== 1'b1 || pending_l !== 8'h08 || merged_l !== 1'b0) begin
          fails++; $display("FAIL regrant_hold: code %0d valid %b pend %h merged %b required 3/1/08/0", code_l, valid_l, pending_l, merged_l);
        end
      end
      if (k == 2) begin
        tests++;
        if (code_l !== 3'd3 || valid_l !== 1'b1 || pending_l !== 8'h00) begin
          fails++; $display("FAIL regrant_again: code %0d valid %b pend %h required 3/1/00", code_l, valid_l, pending_l);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       e, y;
    logic [7:0] r;
    for (int k = 0; k < 300; k++) begin
      e = ($urandom_range(0, 3) != 0);
      y = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      drive(e, r, y);
      got = {code_l, valid_l, pending_l, merged_l}; exp_s = q_l.pop_front();
      tests++;
      if (got !== exp_s) begin fails++; $display("FAIL rand_lo step%0d: got %h required %h", k, got, exp_s); end
      got = {code_h, valid_h, pending_h, merged_h}; exp_s = q_h.pop_front();
      tests++;
      if (got !== exp_s) begin fails++; $display("FAIL rand_hi step%0d: got %h required %h", k, got, exp_s); end
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      void'(q_l.pop_front());
      void'(q_h.pop_front());
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'hF1, 1'b0);
    got = {code_l, valid_l, pending_l, merged_l}; exp_s = q_l.pop_front();
    void'(q_h.pop_front());
    tests++;
    if (got !== exp_s || pending_l !== 8'hF0 || valid_l !== 1'b1) begin
      fails++; $display("FAIL areset_setup: got %h required %h", got, exp_s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({code_l, valid_l, pending_l, merged_l} !== 13'h0 || {code_h, valid_h, pending_h, merged_h} !== 13'h0) begin
      fails++; $display("FAIL areset_async: lo %h hi %h required 0",
                        {code_l, valid_l, pending_l, merged_l}, {code_h, valid_h, pending_h, merged_h});
    end
    m_l = '0; m_h = '0;
    q_l.delete(); q_h.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      got = {code_l, valid_l, pending_l, merged_l}; exp_s = q_l.pop_front();
      void'(q_h.pop_front());
      tests++;
      if (got !== exp_s || valid_l !== 1'b0 || valid_h !== 1'b0) begin
        fails++; $display("FAIL areset_residual step%0d: got %h valid_hi %b required %h", k, got, valid_h, exp_s);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_priority();
    test_merge();
    test_enable();
    test_regrant();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
